tl_dma_channel_engine: RTL and testbench

- Parametrised single-channel DMA engine; next generation of the per-channel core instantiated by the multi-channel DMA controller.
- Adds configurable bus data width, fixed/incrementing source and destination addressing (peripheral FIFO mode), and alignment checking.
- Owns one TileLink-UL master port and moves data in read-then-write beats.
- The register front-end drives the control inputs; status outputs feed the controller's IRQ logic.

---
 rtl/tl_dma_channel_engine.sv | 191 +++++++++++++++++++
 tb/tb_tl_dma_channel_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_dma_channel_engine.sv
// Single-channel TileLink-UL DMA engine: moves len bytes as read-then-write beats with fixed or
// incrementing addressing. Define TL_DMA_ABORT_EN to add abort_i/aborted_o beat-boundary abort.
module tl_dma_channel_engine #(
  parameter int TL_AW  = 32,
  parameter int TL_DW  = 32,
  parameter int TL_RS  = 4,
  parameter int SRC_ID = 0,
  parameter int LEN_W  = 32
) (
  input  logic                 dma_clock_i,
  input  logic                 dma_reset_i,
  input  logic                 start_i,
  input  logic [TL_AW-1:0]     src_i,
  input  logic [TL_AW-1:0]     dst_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 src_inc_i,
  input  logic                 dst_inc_i,
`ifdef TL_DMA_ABORT_EN
  input  logic                 abort_i,
  output logic                 aborted_o,
`endif
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [2:0]           a_opcode,
  output logic [2:0]           a_param,
  output logic [3:0]           a_size,
  output logic [TL_RS-1:0]     a_source,
  output logic [TL_AW-1:0]     a_address,
  output logic [TL_DW/8-1:0]   a_mask,
  output logic [TL_DW-1:0]     a_data,
  output logic                 a_corrupt,
  output logic                 a_valid,
  input  logic                 a_ready,
  input  logic [2:0]           d_opcode,
  input  logic [1:0]           d_param,
  input  logic [3:0]           d_size,
  input  logic [TL_RS-1:0]     d_source,
  input  logic                 d_denied,
  input  logic [TL_DW-1:0]     d_data,
  input  logic                 d_corrupt,
  input  logic                 d_valid,
  output logic                 d_ready
);

  localparam int BEAT  = TL_DW / 8;
  localparam int OFF_W = $clog2(BEAT);

  typedef enum logic [2:0] {
    IDLE, CHECK, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, DONE, ERR
  } state_t;

  state_t             state, state_next;
  logic [TL_AW-1:0]   cur_src, cur_dst;
  logic [LEN_W-1:0]   remaining, rem_next;
  logic               src_inc, dst_inc;
  logic [TL_DW-1:0]   rdata;
  logic               misaligned, rd_ok, wr_ok;
  logic               unused_tl;

  assign rem_next   = remaining - LEN_W'(BEAT);
  assign misaligned = (cur_src[OFF_W-1:0] != '0) || (cur_dst[OFF_W-1:0] != '0) ||
                      (remaining[OFF_W-1:0] != '0);
  assign rd_ok      = !d_denied && !d_corrupt && (d_opcode == 3'd1);
  assign wr_ok      = !d_denied && (d_opcode == 3'd0);

  assign busy_o    = (state != IDLE);
  assign done_o    = (state == DONE);
  assign err_o     = (state == ERR);
  assign a_param   = '0;
  assign a_source  = TL_RS'(SRC_ID);
  assign a_corrupt = 1'b0;
  assign unused_tl = ^{d_param, d_size, d_source};

`ifdef TL_DMA_ABORT_EN
  logic abort_flag, abort_req, abort_go;

  assign abort_req = abort_flag || abort_i;

  // Abort request is remembered until the engine next reaches a beat boundary.
  always_ff @(posedge dma_clock_i or posedge dma_reset_i) begin
    if (dma_reset_i) begin
      abort_flag <= 1'b0;
      aborted_o  <= 1'b0;
    end else begin
      aborted_o <= abort_go;
      if (state == IDLE) abort_flag <= 1'b0;
      else if (abort_i)  abort_flag <= 1'b1;
    end
  end
`endif

  always_ff @(posedge dma_clock_i or posedge dma_reset_i) begin
    if (dma_reset_i) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      src_inc   <= 1'b0;
      dst_inc   <= 1'b0;
      rdata     <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start_i) begin
        cur_src   <= src_i;
        cur_dst   <= dst_i;
        remaining <= len_i;
        src_inc   <= src_inc_i;
        dst_inc   <= dst_inc_i;
      end
      if (state == RD_WAIT && d_valid) rdata <= d_data;
      if (state == WR_WAIT && d_valid && wr_ok) begin
        remaining <= rem_next;
        if (src_inc) cur_src <= cur_src + TL_AW'(BEAT);
        if (dst_inc) cur_dst <= cur_dst + TL_AW'(BEAT);
      end
    end
  end

  // Requests are driven straight from the state so the A payload cannot move while a_valid waits.
  always_comb begin
    state_next = state;
    a_valid    = 1'b0;
    a_opcode   = 3'd0;
    a_size     = 4'd0;
    a_mask     = '0;
    a_address  = '0;
    a_data     = '0;
    d_ready    = 1'b0;
`ifdef TL_DMA_ABORT_EN
    abort_go   = 1'b0;
`endif
    case (state)
      IDLE: if (start_i) state_next = CHECK;
      CHECK: begin
        if (misaligned)              state_next = ERR;
        else if (remaining == '0)    state_next = DONE;
        else begin
          state_next = RD_REQ;
`ifdef TL_DMA_ABORT_EN
          if (abort_req) begin
            state_next = IDLE;
            abort_go   = 1'b1;
          end
`endif
        end
      end
      RD_REQ: begin
        a_valid   = 1'b1;
        a_opcode  = 3'd4;
        a_size    = 4'(OFF_W);
        a_mask    = '1;
        a_address = cur_src;
        if (a_ready) state_next = RD_WAIT;
      end
      RD_WAIT: begin
        d_ready = 1'b1;
        if (d_valid) state_next = rd_ok ? WR_REQ : ERR;
      end
      WR_REQ: begin
        a_valid   = 1'b1;
        a_opcode  = 3'd0;
        a_size    = 4'(OFF_W);
        a_mask    = '1;
        a_address = cur_dst;
        a_data    = rdata;
        if (a_ready) state_next = WR_WAIT;
      end
      WR_WAIT: begin
        d_ready = 1'b1;
        if (d_valid) begin
          if (!wr_ok)               state_next = ERR;
          else if (rem_next == '0)  state_next = DONE;
          else begin
            state_next = RD_REQ;
`ifdef TL_DMA_ABORT_EN
            if (abort_req) begin
              state_next = IDLE;
              abort_go   = 1'b1;
            end
`endif
          end
        end
      end
      DONE:    state_next = IDLE;
      ERR:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_tl_dma_channel_engine.sv
// Self-checking bench for tl_dma_channel_engine: table of whole transfers against a zero-wait
// TileLink slave model, plus hand sequences for denial, A-stall, mid-transfer reset and abort.
module tb_tl_dma_channel_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src = '0, dst = '0, len = '0;
  logic        src_inc = 1'b0, dst_inc = 1'b0;
  logic        busy_o, done_o, err_o;
  logic [2:0]  a_opcode, a_param;
  logic [3:0]  a_size, a_mask;
  logic [3:0]  a_source;
  logic [31:0] a_address, a_data;
  logic        a_corrupt, a_valid, d_ready;
  logic        a_ready = 1'b1;
  logic [2:0]  d_opcode = 3'd0;
  logic [1:0]  d_param = 2'd0;
  logic [3:0]  d_size = 4'd2;
  logic [3:0]  d_source = 4'd0;
  logic        d_denied = 1'b0, d_corrupt = 1'b0, d_valid = 1'b0;
  logic [31:0] d_data = '0;
`ifdef TL_DMA_ABORT_EN
  logic        abort_i = 1'b0;
  logic        aborted_o;
`endif

  always #5 clk = ~clk;

  tl_dma_channel_engine dut (
    .dma_clock_i(clk), .dma_reset_i(rst), .start_i(start),
    .src_i(src), .dst_i(dst), .len_i(len), .src_inc_i(src_inc), .dst_inc_i(dst_inc),
`ifdef TL_DMA_ABORT_EN
    .abort_i(abort_i), .aborted_o(aborted_o),
`endif
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .a_opcode(a_opcode), .a_param(a_param), .a_size(a_size), .a_source(a_source),
    .a_address(a_address), .a_mask(a_mask), .a_data(a_data), .a_corrupt(a_corrupt),
    .a_valid(a_valid), .a_ready(a_ready),
    .d_opcode(d_opcode), .d_param(d_param), .d_size(d_size), .d_source(d_source),
    .d_denied(d_denied), .d_data(d_data), .d_corrupt(d_corrupt), .d_valid(d_valid),
    .d_ready(d_ready)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [3:0]  size;
  } txn_t;

  typedef struct {
    logic [31:0] src, dst, len;
    logic        si, di;
    int          exp_done, exp_err, beats;
  } vec_t;

  txn_t        log_q[$];
  int          total = 0, bad = 0;
  int          reads = 0, deny_read_n = 0;
  int          stall_left = 0, stall_seen = 0, stall_bad = 0;
  logic [31:0] stall_addr = '0;
  logic        resp_due = 1'b0, d_take = 1'b0;
  logic [2:0]  pend_op = '0;
  logic [31:0] pend_addr = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'hCAFE_0000;
  endfunction

  // Slave model works on the falling edge: one response per accepted request, one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      d_valid = 1'b0; resp_due = 1'b0; d_take = 1'b0; a_ready = 1'b1;
    end else begin
      if (d_take) begin d_valid = 1'b0; d_take = 1'b0; end
      if (resp_due) begin
        d_valid  = 1'b1;
        resp_due = 1'b0;
        if (pend_op == 3'd4) begin
          reads++;
          d_opcode = 3'd1;
          d_data   = mem_word(pend_addr);
          d_denied = (reads == deny_read_n);
        end else begin
          d_opcode = 3'd0; d_data = '0; d_denied = 1'b0;
        end
      end
      if (a_valid && stall_left > 0) begin
        a_ready = 1'b0;
        stall_left--;
        stall_seen++;
        if (a_address !== stall_addr || a_opcode !== 3'd4) stall_bad++;
      end else begin
        a_ready = 1'b1;
      end
      if (a_valid && a_ready) begin
        log_q.push_back('{a_opcode, a_address, a_data, a_mask, a_size});
        pend_op = a_opcode; pend_addr = a_address; resp_due = 1'b1;
      end
      d_take = d_valid && d_ready;
    end
  end

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Pulses start for one cycle then watches done/err until the engine settles back to idle.
  task automatic apply_stimulus(input logic [31:0] s, d, l, input logic si, di,
                                output int n_done, output int n_err, output int first_cyc,
                                output logic busy_after, output logic timeout);
    n_done = 0; n_err = 0; first_cyc = -1; busy_after = 1'b1; timeout = 1'b1;
    @(negedge clk);
    src = s; dst = d; len = l; src_inc = si; dst_inc = di; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      if (done_o) n_done++;
      if (err_o)  n_err++;
      if ((done_o || err_o) && first_cyc < 0) first_cyc = c;
      if (first_cyc >= 0 && c == first_cyc + 1) begin busy_after = busy_o; timeout = 1'b0; end
      if (first_cyc >= 0 && c >= first_cyc + 3) break;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  vec_t        vecs[8];
  int          n_done, n_err, first_cyc;
  logic        busy_after, timeout;
  logic [31:0] ga, pa;
  int          nlog;

  initial begin
    vecs[0] = '{32'h1000,     32'h2000, 32'd8,  1'b1, 1'b1, 1, 0, 2};
    vecs[1] = '{32'h1000,     32'h3000, 32'd12, 1'b1, 1'b0, 1, 0, 3};
    vecs[2] = '{32'h1002,     32'h2000, 32'd8,  1'b1, 1'b1, 0, 1, 0};
    vecs[3] = '{32'h1000,     32'h2001, 32'd4,  1'b1, 1'b1, 0, 1, 0};
    vecs[4] = '{32'h1000,     32'h2000, 32'd6,  1'b1, 1'b1, 0, 1, 0};
    vecs[5] = '{32'h1000,     32'h2000, 32'd0,  1'b1, 1'b1, 1, 0, 0};
    vecs[6] = '{32'h4000,     32'h5000, 32'd8,  1'b0, 1'b1, 1, 0, 2};
    vecs[7] = '{32'hFFFF_FFFC, 32'h10,  32'd8,  1'b1, 1'b1, 1, 0, 2};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_output("reset busy",    busy_o,    0);
    check_output("reset done",    done_o,    0);
    check_output("reset err",     err_o,     0);
    check_output("reset a_valid", a_valid,   0);
    check_output("reset d_ready", d_ready,   0);
    check_output("reset corrupt", a_corrupt, 0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      log_q.delete();
      apply_stimulus(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].si, vecs[v].di,
                     n_done, n_err, first_cyc, busy_after, timeout);
      check_output($sformatf("v%0d timeout", v), timeout, 0);
      check_output($sformatf("v%0d done cnt", v), n_done, vecs[v].exp_done);
      check_output($sformatf("v%0d err cnt", v), n_err, vecs[v].exp_err);
      check_output($sformatf("v%0d busy after", v), busy_after, 0);
      check_output($sformatf("v%0d txn cnt", v), log_q.size(), 2 * vecs[v].beats);
      if (vecs[v].exp_err != 0)
        check_output($sformatf("v%0d err latency<=2", v), (first_cyc >= 1 && first_cyc <= 2), 1);
      for (int i = 0; i < vecs[v].beats && 2 * i + 1 < log_q.size(); i++) begin
        ga = vecs[v].src + (vecs[v].si ? 32'(4 * i) : 32'd0);
        pa = vecs[v].dst + (vecs[v].di ? 32'(4 * i) : 32'd0);
        check_output($sformatf("v%0d get%0d op", v, i),   log_q[2*i].op,     3'd4);
        check_output($sformatf("v%0d get%0d addr", v, i), log_q[2*i].addr,   ga);
        check_output($sformatf("v%0d put%0d op", v, i),   log_q[2*i+1].op,   3'd0);
        check_output($sformatf("v%0d put%0d addr", v, i), log_q[2*i+1].addr, pa);
        check_output($sformatf("v%0d put%0d data", v, i), log_q[2*i+1].data, mem_word(ga));
      end
      if (v == 0 && log_q.size() >= 2) begin
        check_output("get size", log_q[0].size, 4'd2);
        check_output("get mask", log_q[0].mask, 4'hF);
        check_output("put mask", log_q[1].mask, 4'hF);
      end
    end

    // Second read denied: error, no second Put, then a fresh transfer still works.
    log_q.delete(); reads = 0; deny_read_n = 2;
    apply_stimulus(32'h1000, 32'h2000, 32'd8, 1'b1, 1'b1, n_done, n_err, first_cyc, busy_after, timeout);
    deny_read_n = 0;
    check_output("deny err cnt", n_err, 1);
    check_output("deny done cnt", n_done, 0);
    check_output("deny busy after", busy_after, 0);
    check_output("deny txn cnt", log_q.size(), 3);
    if (log_q.size() >= 3) check_output("deny last get", log_q[2].addr, 32'h1004);
    log_q.delete();
    apply_stimulus(32'h1000, 32'h2000, 32'd4, 1'b1, 1'b1, n_done, n_err, first_cyc, busy_after, timeout);
    check_output("recover done cnt", n_done, 1);
    check_output("recover txn cnt", log_q.size(), 2);

    // A-channel held off for five cycles: request must hold address and opcode.
    log_q.delete(); stall_addr = 32'h6000; stall_seen = 0; stall_bad = 0; stall_left = 5;
    apply_stimulus(32'h6000, 32'h7000, 32'd4, 1'b1, 1'b1, n_done, n_err, first_cyc, busy_after, timeout);
    check_output("stall cycles", stall_seen, 5);
    check_output("stall unstable", stall_bad, 0);
    check_output("stall done cnt", n_done, 1);
    if (log_q.size() >= 2) check_output("stall put data", log_q[1].data, mem_word(32'h6000));

    // Reset in the middle of a transfer stops all bus traffic.
    log_q.delete();
    @(negedge clk);
    src = 32'h1000; dst = 32'h2000; len = 32'd16; src_inc = 1'b1; dst_inc = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_output("midreset busy", busy_o, 0);
    check_output("midreset a_valid", a_valid, 0);
    rst = 1'b0;
    nlog = log_q.size();
    repeat (10) @(negedge clk);
    check_output("midreset no traffic", log_q.size(), nlog);
    check_output("midreset idle", busy_o, 0);

`ifdef TL_DMA_ABORT_EN
    begin
      int   na, nd, ne;
      logic found;
      log_q.delete();
      @(negedge clk);
      src = 32'h1000; dst = 32'h2000; len = 32'd16; src_inc = 1'b1; dst_inc = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
        if (d_ready) found = 1'b1;
        else @(negedge clk);
      end
      check_output("abort reached rd_wait", found, 1);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      na = 0; nd = 0; ne = 0;
      for (int c = 0; c < 60; c++) begin
        if (aborted_o) na++;
        if (done_o)    nd++;
        if (err_o)     ne++;
        @(negedge clk);
      end
      check_output("abort pulse cnt", na, 1);
      check_output("abort done cnt", nd, 0);
      check_output("abort err cnt", ne, 0);
      check_output("abort busy", busy_o, 0);
      check_output("abort txn cnt", log_q.size(), 2);
      if (log_q.size() >= 2) begin
        check_output("abort get addr", log_q[0].addr, 32'h1000);
        check_output("abort put addr", log_q[1].addr, 32'h2000);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
